// File: rtl/output_requant_fifo_pkg.sv
// output_requant_fifo_pkg: saturation limits and FIFO entry layout shared by the requant FIFO
package output_requant_fifo_pkg;
  localparam int DATA_W = 16;
  localparam int X_W = 10;
  localparam int Y_W = 10;
  localparam int CH_W = 6;
  function automatic longint sat_hi(int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction
  function automatic longint sat_lo(int w);
    return -(longint'(1) << (w - 1));
  endfunction
  localparam longint SAT_MAX = sat_hi(DATA_W);
  localparam longint SAT_MIN = sat_lo(DATA_W);
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [CH_W-1:0] ch;
  } entry_t;
endpackage

// File: rtl/output_requant_fifo_requant_sat.sv
// requant_sat: round-half-up arithmetic shift followed by signed saturation to the output width
module requant_sat
  import output_requant_fifo_pkg::*;
#(
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int IO_DATA_WIDTH = 16,
  parameter int OUTPUT_SCALE = 0
) (
  input  logic [ACCUMULATION_WIDTH-1:0] in_data,
  output logic [IO_DATA_WIDTH-1:0]      out_data,
  output logic                          sat
);
  localparam int AW = ACCUMULATION_WIDTH;
  localparam logic signed [AW:0] HALF = (AW+1)'((longint'(1) << OUTPUT_SCALE) >>> 1);
  localparam logic signed [AW:0] HI = (AW+1)'(sat_hi(IO_DATA_WIDTH));
  localparam logic signed [AW:0] LO = (AW+1)'(sat_lo(IO_DATA_WIDTH));
  logic signed [AW:0] ext;
  logic signed [AW:0] r;
  logic hi;
  logic lo;
  // one extra bit keeps the rounding add from overflowing
  always_comb begin
    ext = {in_data[AW-1], in_data};
    r = (ext + HALF) >>> OUTPUT_SCALE;
    hi = r > HI;
    lo = r < LO;
    sat = hi | lo;
    out_data = hi ? HI[IO_DATA_WIDTH-1:0] : lo ? LO[IO_DATA_WIDTH-1:0] : r[IO_DATA_WIDTH-1:0];
  end
endmodule

// File: rtl/output_requant_fifo.sv
// output_requant_fifo: requantizes tagged accumulator results and buffers them in a small FIFO
module output_requant_fifo
  import output_requant_fifo_pkg::*;
#(
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int IO_DATA_WIDTH = DATA_W,
  parameter int OUTPUT_SCALE = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int FEATURE_MAP_WIDTH = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64,
  localparam int XW = $clog2(FEATURE_MAP_WIDTH),
  localparam int YW = $clog2(FEATURE_MAP_HEIGHT),
  localparam int CW = $clog2(OUTPUT_NB_CHANNELS),
  localparam int PW = $clog2(FIFO_DEPTH)
) (
  input  logic                          clk,
  input  logic                          arst_n_in,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ACCUMULATION_WIDTH-1:0] in_data,
  input  logic [XW-1:0]                 in_x,
  input  logic [YW-1:0]                 in_y,
  input  logic [CW-1:0]                 in_ch,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IO_DATA_WIDTH-1:0]      out_data,
  output logic [XW-1:0]                 out_x,
  output logic [YW-1:0]                 out_y,
  output logic [CW-1:0]                 out_ch,
  output logic [PW:0]                   fill_level,
  output logic                          overflow,
  output logic [15:0]                   sat_count
);
  entry_t mem [FIFO_DEPTH];
  entry_t wr_entry;
  entry_t head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [IO_DATA_WIDTH-1:0] rq_data;
  logic rq_sat;
  logic push;
  logic pop;
  requant_sat #(
    .ACCUMULATION_WIDTH(ACCUMULATION_WIDTH),
    .IO_DATA_WIDTH(IO_DATA_WIDTH),
    .OUTPUT_SCALE(OUTPUT_SCALE)
  ) u_requant_sat (
    .in_data(in_data),
    .out_data(rq_data),
    .sat(rq_sat)
  );
  // handshake depends only on registered fill level, never on out_ready
  always_comb begin
    in_ready = fill_level != (PW+1)'(FIFO_DEPTH);
    out_valid = fill_level != '0;
    push = in_valid & in_ready;
    pop = out_valid & out_ready;
    wr_entry = '{data: rq_data, x: in_x, y: in_y, ch: in_ch};
    head = mem[rd_ptr];
    out_data = head.data;
    out_x = head.x;
    out_y = head.y;
    out_ch = head.ch;
  end
  // pointers, occupancy and status flags; clear beats any same-cycle push or pop
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_level <= '0;
      overflow <= 1'b0;
      sat_count <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_level <= '0;
      overflow <= 1'b0;
      sat_count <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      fill_level <= fill_level + (PW+1)'(push) - (PW+1)'(pop);
      overflow <= overflow | (in_valid & ~in_ready);
      sat_count <= (push && rq_sat && sat_count != 16'hFFFF) ? sat_count + 16'd1 : sat_count;
    end
  end
  // storage needs no reset; stale slots are unreachable once the pointers are cleared
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end
endmodule
